// File: rtl/pid_pwm_out.sv
// pid_pwm_out: PWM actuator stage of the PID controller.
// Takes a signed control value over valid/ready, maps it to a duty cycle,
// double-buffers it and applies it at a PWM period boundary.
// Optional build macro PID_PWM_SIGNMAG_EN selects sign-magnitude drive
// (duty = saturated 2*|u|, direction on dir_out) instead of offset binary.
module pid_pwm_out #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    u_valid,
   input  logic signed [WIDTH-1:0] u_data,
   output logic                    u_ready,
   output logic                    pwm_out,
   output logic                    dir_out,
   output logic                    period_start,
   output logic        [WIDTH-1:0] duty_q
);

   localparam int               PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] CNT_LAST   = {{(WIDTH-1){1'b1}}, 1'b0};
`ifdef PID_PWM_SIGNMAG_EN
   localparam logic [WIDTH-1:0] DUTY_RST   = '0;
`else
   localparam logic [WIDTH-1:0] DUTY_RST   = {1'b1, {(WIDTH-1){1'b0}}};
`endif

`ifdef PID_PWM_SIGNMAG_EN
   // Clamp a doubled magnitude to the largest representable duty.
   function automatic logic [WIDTH-1:0] sat_duty(input logic [WIDTH+1:0] v);
      return (v > {2'b00, {WIDTH{1'b1}}}) ? {WIDTH{1'b1}} : v[WIDTH-1:0];
   endfunction
`endif

   // Control value to duty mapping.
   function automatic logic [WIDTH-1:0] map_duty(input logic signed [WIDTH-1:0] u);
`ifdef PID_PWM_SIGNMAG_EN
      logic [WIDTH:0] mag;
      mag = u[WIDTH-1] ? ({1'b0, ~u} + (WIDTH+1)'(1)) : {1'b0, u};
      return sat_duty({mag, 1'b0});
`else
      return {~u[WIDTH-1], u[WIDTH-2:0]};
`endif
   endfunction

   logic [PW-1:0]    presc;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] duty_p0;
   logic             vld_p0;
   logic             tick;
   logic             boundary;
   logic             take;
   logic             apply;

   assign tick     = enable && (presc == PRESC_LAST);
   assign boundary = tick && (cnt == CNT_LAST);
   assign u_ready  = !vld_p0 && !rst;
   assign take     = u_valid && u_ready;
   // With the PWM stopped there is no period to protect, so apply at once.
   assign apply    = vld_p0 && (enable ? boundary : 1'b1);

   // Prescaler and period counter; both parked at 0 while disabled.
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         presc <= '0;
         cnt   <= '0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick) cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
   end

   // ---- stage p0: pending duty buffer ----
   // Pending-valid flag; only one value can wait for the boundary.
   always_ff @(posedge clk) begin
      if (rst)        vld_p0 <= 1'b0;
      else if (take)  vld_p0 <= 1'b1;
      else if (apply) vld_p0 <= 1'b0;
   end

   // Pending duty data; meaningless while vld_p0 is low, so not reset.
   always_ff @(posedge clk) begin
      if (take) duty_p0 <= map_duty(u_data);
   end

   // ---- stage p1: applied duty ----
   // Active duty register, loaded from the pending buffer.
   always_ff @(posedge clk) begin
      if (rst)        duty_q <= DUTY_RST;
      else if (apply) duty_q <= duty_p0;
   end

`ifdef PID_PWM_SIGNMAG_EN
   logic dir_p0;
   logic dir_q;

   // Direction travels with the pending duty and switches on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         dir_q <= 1'b0;
      end else begin
         if (take)  dir_p0 <= u_data[WIDTH-1];
         if (apply) dir_q  <= dir_p0;
      end
   end

   assign dir_out = dir_q;
`else
   assign dir_out = 1'b0;
`endif

   // ---- stage p2: registered outputs ----
   // PWM compare and period-start strobe, one clk behind the counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_out      <= 1'b0;
         period_start <= 1'b0;
      end else begin
         pwm_out      <= enable && (cnt < duty_q);
         period_start <= boundary;
      end
   end

endmodule

// File: doc/pid_pwm_out.md
# pid_pwm_out

Output actuator stage of the PID controller, downstream of the PID compute core. It accepts a signed control value over a valid/ready handshake and maps it to a PWM duty cycle. The duty is double-buffered so updates take effect only at a PWM period boundary, and the stage drives one PWM pin with a period-start strobe.

## Interface
- `WIDTH`, default 8: control value and PWM counter width, ≥ 2.
- `PRESCALE`, default 4: clk cycles per PWM tick, ≥ 1.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `enable` in 1: 1 runs the PWM; 0 holds counters and forces output low.
- `u_valid` in 1: control value offered.
- `u_data` in WIDTH: signed two's-complement control value.
- `u_ready` out 1: stage can take a value.
- `pwm_out` out 1: PWM output, registered.
- `dir_out` out 1: direction; constant 0 unless the configured feature is enabled.
- `period_start` out 1: one-clk pulse at each period boundary.
- `duty_q` out WIDTH: duty currently applied.

## Operation
- Prescaler `presc` counts 0..PRESCALE-1. A tick occurs on the clk where `presc == PRESCALE-1`; `presc` then wraps to 0.
- Period counter `cnt` advances by 1 per tick over 0..2^WIDTH-2 and wraps to 0. Period = 2^WIDTH-1 ticks.
- Boundary: a tick while `cnt == 2^WIDTH-2`. `cnt` becomes 0 on that edge.
- Mapping (default, offset binary): `duty = u_data + 2^(WIDTH-1)` (MSB inverted). -128→0, 0→128, 127→255 for WIDTH=8.
- Handshake:
  - `u_ready = !pend_v && !rst`.
  - A transfer happens when `u_valid && u_ready`. The mapped value goes into `pend` and `pend_v` is set to 1.
  - `u_data` is sampled only on a transfer.
- Apply:
  - When `enable` = 1: at a boundary with `pend_v` = 1, `duty_q <= pend` and `pend_v <= 0`.
  - When `enable` = 0: any cycle with `pend_v` = 1 applies `pend` immediately.
- Simultaneous events: a transfer on the same edge as a boundary with empty `pend` lands in `pend`. It is applied at the next boundary, not the current one.
- Output: `pwm_out <= enable && (cnt < duty_q)`, computed from current register values. `duty_q` = 0 gives always low; `duty_q` = 2^WIDTH-1 gives always high.
- Enable low: `presc` and `cnt` are held at 0 and `pwm_out` goes to 0. `period_start` stays 0. `pend`/`duty_q` still update as above.
- Enable rise: counting resumes from `cnt` = 0 and `presc` = 0.
- Reset values:
  - `presc` 0, `cnt` 0, `pend_v` 0, `pwm_out` 0, `period_start` 0, `dir_out` 0, `u_ready` 0 while `rst` = 1.
  - `duty_q` = 2^(WIDTH-1) (zero control) by default; 0 with the macro.
- Reset mid-period aborts the period immediately. A pending value is discarded.

## Timing
- `pwm_out` lags `cnt`/`duty_q` by 1 clk.
- `period_start` is high exactly on the clk after a boundary edge, i.e. while `cnt` = 0 and `presc` = 0 following a wrap. It is not asserted after reset or after an enable rise.
- Transfer to applied duty: at most one full period plus 1 clk. At least 1 clk when `enable` = 0.
- `u_ready` rises 1 clk after reset release and 1 clk after `pend` is applied.
- At most one buffered value; further offers stall.
- No combinational path from `u_valid` to `u_ready`.

## Configuration
- `PID_PWM_SIGNMAG_EN` defined (sign-magnitude drive for an H-bridge):
  - `duty = min(2·|u_data|, 2^WIDTH-1)`.
  - `dir_out` = sign of `u_data`, buffered with `pend` and applied on the same edge as `duty_q`.
  - Reset `duty_q` = 0, `dir_out` = 0.
  - WIDTH=8 examples: 127→254, -64→128 with dir 1, -128→255 with dir 1.
- `PID_PWM_SIGNMAG_EN` undefined: offset-binary mapping, `dir_out` tied 0.

## Test plan
All scenarios use WIDTH=8, PRESCALE=1 (period 255 clk) unless noted.
- Reset default: after `rst`, `enable`=1, no input → `duty_q`=128; `pwm_out` high 128 of every 255 clk; `period_start` every 255 clk.
- Extremes: send -128 → after next boundary `pwm_out` constant 0. Send 127 → constant 1.
- Backpressure:
  - Send 0x10 mid-period → accepted and `u_ready` drops.
  - Hold 0x20 valid → stalls until 1 clk after the boundary, then is accepted.
  - `duty_q` sequence: 0x90, then 0xA0 one period later.
- Boundary collision: offer 0x40 with `pend` empty on the boundary edge → `duty_q` unchanged that period; 0xC0 applied at the following boundary.
- Enable/reset: `enable`=0 mid-period → `pwm_out` 0 after 1 clk, `cnt` 0. `rst` mid-period with a pending value → all reset values, pending value lost.
- PRESCALE=4 with `PID_PWM_SIGNMAG_EN`: send -64 → `duty_q`=128 and `dir_out`=1 at boundary; `pwm_out` high 512 of 1020 clk.
